// File: rtl/command_fifo_mc.sv
// rtl/command_fifo_mc.sv - multi-channel command FIFO with round-robin registered output
// NUM_CH independent queues share one valid/ready output port.
module command_fifo_mc #(
   parameter int NUM_CH   = 4,
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_CH-1:0]                       wr_en,
   input  logic [NUM_CH*WIDTH-1:0]                 wr_data,
   output logic [NUM_CH-1:0]                       full,
   output logic [NUM_CH-1:0]                       almost_full,
   output logic [NUM_CH-1:0]                       overflow,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]     count,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [WIDTH-1:0]                        out_data,
   output logic [(NUM_CH>1?$clog2(NUM_CH):1)-1:0]  out_ch
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [WIDTH-1:0] mem    [NUM_CH][DEPTH];
   logic [PW-1:0]    wr_ptr [NUM_CH];
   logic [PW-1:0]    rd_ptr [NUM_CH];
   logic [PW-1:0]    cnt    [NUM_CH];
   logic [NUM_CH-1:0] empty;
   logic [CHW-1:0]   rr_last;
   logic [CHW-1:0]   gnt;
   logic [CHW-1:0]   cand;
   logic             gnt_found;
   logic             load;
   int               idx;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cnt[c]               = wr_ptr[c] - rd_ptr[c];
         empty[c]             = (wr_ptr[c] == rd_ptr[c]);
         full[c]              = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                                (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
         almost_full[c]       = int'(cnt[c]) >= AF_LEVEL;
         count[c*PW +: PW]    = cnt[c];
      end
   end

   // Search starts just after the last granted channel, so each grant rotates priority.
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      idx       = 0;
      cand      = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx  = (int'(rr_last) + i) % NUM_CH;
         cand = CHW'(idx);
         if (!gnt_found && !empty[cand]) begin
            gnt_found = 1'b1;
            gnt       = cand;
         end
      end
   end

   assign load = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en[c] && !full[c])
               mem[c][wr_ptr[c][AW-1:0]] <= wr_data[c*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
         overflow  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_last   <= CHW'(NUM_CH - 1);
      end else begin
         // Full is judged on start-of-cycle state: a same-cycle pop never frees room.
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en[c]) begin
               if (full[c])
                  overflow[c] <= 1'b1;
               else
                  wr_ptr[c] <= wr_ptr[c] + PW'(1);
            end
         end
         if (load) begin
            if (gnt_found) begin
               out_data    <= mem[gnt][rd_ptr[gnt][AW-1:0]];
               out_ch      <= gnt;
               out_valid   <= 1'b1;
               rd_ptr[gnt] <= rd_ptr[gnt] + PW'(1);
               rr_last     <= gnt;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_command_fifo_mc.sv
// tb/tb_command_fifo_mc.sv - randomized scoreboard bench for command_fifo_mc
// Queue-level reference model predicts each output; a negedge monitor compares.
module tb_command_fifo_mc;

   localparam int NCH = 2;
   localparam int DEP = 4;
   localparam int W   = 16;
   localparam int PW  = 3;

   typedef struct packed {
      logic [3:0]  ch;
      logic [15:0] data;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NCH-1:0]    wr_en = '0;
   logic [NCH*W-1:0]  wr_data = '0;
   logic              out_ready = 1'b0;
   logic [NCH-1:0]    full, almost_full, overflow;
   logic [NCH*PW-1:0] count;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [0:0]        out_ch;

   command_fifo_mc #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .AF_LEVEL(DEP-2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .overflow(overflow), .count(count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0]    mq [NCH][$];
   logic [NCH-1:0] m_ovf = '0;
   logic           m_ov = 1'b0;
   logic [15:0]    m_od = '0;
   int             m_oc = 0;
   int             m_rr = NCH - 1;
   ent_t           exp_q[$];
   ent_t           rx_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: per-channel queues plus one output slot, updated once per clock edge.
   task automatic model_step();
      int  g;
      int  c;
      bit  found;
      if (rst) begin
         for (int k = 0; k < NCH; k++) mq[k].delete();
         m_ovf = '0; m_ov = 1'b0; m_od = '0; m_oc = 0; m_rr = NCH - 1;
         exp_q.delete();
      end else begin
         found = 1'b0;
         g = 0;
         for (int i = 1; i <= NCH; i++) begin
            c = (m_rr + i) % NCH;
            if (!found && mq[c].size() > 0) begin
               found = 1'b1;
               g = c;
            end
         end
         for (int k = 0; k < NCH; k++) begin
            if (wr_en[k]) begin
               if (mq[k].size() == DEP) m_ovf[k] = 1'b1;
               else mq[k].push_back(wr_data[k*W +: W]);
            end
         end
         if (!m_ov || out_ready) begin
            if (found) begin
               m_od = mq[g].pop_front();
               m_oc = g;
               m_ov = 1'b1;
               m_rr = g;
               exp_q.push_back({4'(g), m_od});
            end else begin
               m_ov = 1'b0;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      ent_t e;
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_data", out_data, m_od);
         chk("out_ch", out_ch, m_oc);
      end
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("count%0d", c), count[c*PW +: PW], mq[c].size());
         chk($sformatf("full%0d", c), full[c], mq[c].size() == DEP);
         chk($sformatf("almost_full%0d", c), almost_full[c], mq[c].size() >= DEP - 2);
         chk($sformatf("overflow%0d", c), overflow[c], m_ovf[c]);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: transfer ch=%0d data=%0h with nothing expected", out_ch, out_data);
         end else begin
            e = exp_q.pop_front();
            chk("sb_ch", out_ch, e.ch);
            chk("sb_data", out_data, e.data);
         end
         rx_q.push_back({4'(out_ch), out_data});
      end
   end

   task automatic cyc(input logic r, input logic [NCH-1:0] we, input logic [NCH*W-1:0] wd, input logic rd);
      rst = r; wr_en = we; wr_data = wd; out_ready = rd;
      @(posedge clk);
      model_step();
      #1;
   endtask

   logic [19:0] t3_exp [4];
   int          sent;
   logic        w;

   initial begin
      t3_exp = '{20'h00001, 20'h11001, 20'h00002, 20'h11002};

      cyc(1'b1, 2'b00, '0, 1'b0);
      cyc(1'b1, 2'b11, {16'hDEAD, 16'hBEEF}, 1'b1);
      chk("reset_valid", out_valid, 0);
      chk("reset_count", count, 0);

      // Fill ch0 with out_ready low.
      for (int k = 0; k < 5; k++) cyc(1'b0, 2'b01, {16'h0, 16'(16'hA001 + k)}, 1'b0);
      chk("t1_held", out_data, 32'hA001);
      chk("t1_full0", full[0], 1);
      chk("t1_count0", count[PW-1:0], 4);
      chk("t1_af0", almost_full[0], 1);

      cyc(1'b0, 2'b01, {16'h0, 16'hBEEF}, 1'b0);
      chk("t2_ovf", overflow[0], 1);
      cyc(1'b0, 2'b00, '0, 1'b0);
      chk("t2_ovf_sticky", overflow[0], 1);
      rx_q.delete();
      repeat (6) cyc(1'b0, 2'b00, '0, 1'b1);
      chk("t2_rx_size", rx_q.size(), 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("t2_rx%0d", k), (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD0000, 20'h0A001 + k);
      chk("t2_ovf_after_drain", overflow[0], 1);

      // Round robin from reset: ch0 first.
      cyc(1'b1, 2'b00, '0, 1'b0);
      rx_q.delete();
      cyc(1'b0, 2'b11, {16'h1001, 16'h0001}, 1'b0);
      cyc(1'b0, 2'b11, {16'h1002, 16'h0002}, 1'b0);
      repeat (6) cyc(1'b0, 2'b00, '0, 1'b1);
      chk("t3_rx_size", rx_q.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t3_rx%0d", k), (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD0000, t3_exp[k]);

      // Stall pattern 1,0,0,1 while streaming.
      rx_q.delete();
      for (int k = 0; k < 12; k++) begin
         logic [1:0] pat;
         pat = 2'b10;
         cyc(1'b0, (k < 4) ? 2'b11 : 2'b00, {16'($urandom), 16'($urandom)}, (k % 4 == 0) || (k % 4 == 3));
      end
      repeat (8) cyc(1'b0, 2'b00, '0, 1'b1);
      chk("t4_rx_size", rx_q.size(), 8);

      // Pointer wrap on ch1.
      cyc(1'b1, 2'b00, '0, 1'b0);
      rx_q.delete();
      sent = 0;
      for (int k = 0; k < 500 && sent < 37; k++) begin
         w = ($urandom_range(0, 2) != 0) && (mq[1].size() < DEP);
         cyc(1'b0, {w, 1'b0}, {16'(sent), 16'h0}, $urandom_range(0, 3) != 0);
         if (w) sent++;
      end
      repeat (10) cyc(1'b0, 2'b00, '0, 1'b1);
      chk("t5_rx_size", rx_q.size(), 37);
      for (int k = 0; k < 37; k++)
         chk($sformatf("t5_rx%0d", k), (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD0000, 20'h10000 + k);

      // Reset mid-stream.
      for (int k = 0; k < 4; k++) cyc(1'b0, 2'b01, {16'h0, 16'(16'hC000 + k)}, 1'b0);
      chk("t6_pre_valid", out_valid, 1);
      chk("t6_pre_count0", count[PW-1:0], 3);
      cyc(1'b1, 2'b11, {16'h7777, 16'h7777}, 1'b0);
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_ovf", overflow, 0);
      cyc(1'b0, 2'b10, {16'h5A5A, 16'h0}, 1'b0);
      chk("t6_lat1_valid", out_valid, 0);
      cyc(1'b0, 2'b00, '0, 1'b0);
      chk("t6_lat2_valid", out_valid, 1);
      chk("t6_lat2_ch", out_ch, 1);
      chk("t6_lat2_data", out_data, 32'h5A5A);

      // Random traffic with occasional reset.
      for (int k = 0; k < 600; k++)
         cyc($urandom_range(0, 99) == 0, 2'($urandom), {16'($urandom), 16'($urandom)}, $urandom_range(0, 2) != 0);
      repeat (12) cyc(1'b0, 2'b00, '0, 1'b1);
      chk("end_valid", out_valid, 0);
      chk("end_count", count, 0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
